// File: rtl/rc_arb_unit_if.sv
// Output-port encoding and the request/route bundle between the
// input buffer and the shared route-computation stage.
package rc_arb_pkg;
    typedef enum logic [3:0] {
        DLA0, DLA1, DLA2, DLA3,
        SKIP, WEST, EAST, NORTH, SOUTH
    } port_t;
endpackage

interface rc_arb_unit_if #(
    parameter int VC_NUM = 2,
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int L      = 3
);
    import rc_arb_pkg::*;

    logic  [VC_NUM-1:0]        req_valid;
    logic  [VC_NUM-1:0][X-1:0] x_dest;
    logic  [VC_NUM-1:0][Y-1:0] y_dest;
    logic  [VC_NUM-1:0][L-1:0] l_dest;
    logic  [VC_NUM-1:0]        req_ready;
    logic  [VC_NUM-1:0]        tail;
    logic  [VC_NUM-1:0]        route_valid;
    port_t [VC_NUM-1:0]        out_port;

    modport master (
        output req_valid, x_dest, y_dest, l_dest, tail,
        input  req_ready, route_valid, out_port
    );

    modport slave (
        input  req_valid, x_dest, y_dest, l_dest, tail,
        output req_ready, route_valid, out_port
    );
endinterface

// File: rtl/rc_arb_unit.sv
// Shared round-robin route computation (DOR + DLA + SKIP) per VC.
// Define RC_YX_MODE_EN to add yx_mode (resolve Y before X).
module rc_arb_unit
    import rc_arb_pkg::*;
#(
    parameter int DEST_ADDR_SIZE_X = 4,
    parameter int DEST_ADDR_SIZE_Y = 4,
    parameter int DEST_ADDR_SIZE_L = 3,
    parameter int VC_NUM           = 2,
    parameter int NUM_LOCAL        = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DEST_ADDR_SIZE_X-1:0] x_current,
    input  logic [DEST_ADDR_SIZE_Y-1:0] y_current,
    input  logic                        enable_skip,
    input  logic [DEST_ADDR_SIZE_X-1:0] x_skip_dest,
    input  logic [DEST_ADDR_SIZE_Y-1:0] y_skip_dest,
`ifdef RC_YX_MODE_EN
    input  logic                        yx_mode,
`endif
    rc_arb_unit_if.slave                rc
);
    localparam int X  = DEST_ADDR_SIZE_X;
    localparam int Y  = DEST_ADDR_SIZE_Y;
    localparam int L  = DEST_ADDR_SIZE_L;
    localparam int PW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic {IDLE, ROUTED} state_t;

    state_t              state_q [VC_NUM];
    state_t              state_d [VC_NUM];
    port_t  [VC_NUM-1:0] port_q;
    logic   [PW-1:0]     rr_q;
    logic   [VC_NUM-1:0] grant;
    logic                any_grant;
    logic   [PW-1:0]     gidx;
    port_t               route;
    logic                yx;

`ifdef RC_YX_MODE_EN
    assign yx = yx_mode;
`else
    assign yx = 1'b0;
`endif

    // first idle requester at or after the round-robin pointer
    always_comb begin
        int v;
        v         = 0;
        grant     = '0;
        any_grant = 1'b0;
        gidx      = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            v = (int'(rr_q) + i) % VC_NUM;
            if (!any_grant && state_q[v] == IDLE && rc.req_valid[v]) begin
                grant[v]  = 1'b1;
                any_grant = 1'b1;
                gidx      = PW'(v);
            end
        end
    end

    assign rc.req_ready = rst_n ? grant : '0;

    always_comb begin
        logic [X-1:0]    xd;
        logic [Y-1:0]    yd;
        logic [L-1:0]    ld;
        logic signed [X:0] dx;
        logic signed [Y:0] dy;
        xd    = rc.x_dest[gidx];
        yd    = rc.y_dest[gidx];
        ld    = rc.l_dest[gidx];
        dx    = $signed({1'b0, xd}) - $signed({1'b0, x_current});
        dy    = $signed({1'b0, yd}) - $signed({1'b0, y_current});
        route = DLA0;
        if (dx == 0 && dy == 0) begin
            if (int'(ld) < NUM_LOCAL)
                route = port_t'({2'b00, ld[1:0]});
            else if (enable_skip)
                route = port_t'(4'(NUM_LOCAL - 1));
            else
                route = SKIP;
        end else if (enable_skip && xd == x_skip_dest && yd == y_skip_dest) begin
            route = SKIP;
        end else if (!yx) begin
            if (dx < 0)      route = WEST;
            else if (dx > 0) route = EAST;
            else if (dy < 0) route = NORTH;
            else             route = SOUTH;
        end else begin
            if (dy < 0)      route = NORTH;
            else if (dy > 0) route = SOUTH;
            else if (dx < 0) route = WEST;
            else             route = EAST;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= IDLE;
                port_q[v]  <= DLA0;
            end
            rr_q <= '0;
        end else begin
            state_q <= state_d;
            for (int v = 0; v < VC_NUM; v++)
                if (rc.req_ready[v]) port_q[v] <= route;
            if (any_grant)
                rr_q <= PW'((int'(gidx) + 1) % VC_NUM);
        end
    end

    // a tail only releases a held route; new requests need IDLE first
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v] = state_q[v];
            unique case (state_q[v])
                IDLE:   if (rc.req_ready[v]) state_d[v] = ROUTED;
                ROUTED: if (rc.tail[v])      state_d[v] = IDLE;
                default: state_d[v] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int v = 0; v < VC_NUM; v++)
            rc.route_valid[v] = (state_q[v] == ROUTED);
        rc.out_port = port_q;
    end
endmodule

// File: tb/tb_rc_arb_unit.sv
// Directed and random checks of rc_arb_unit against a
// behavioural route/arbitration model.
module tb_rc_arb_unit;
    import rc_arb_pkg::*;

    localparam int VC = 2;
    localparam int NL = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] x_cur, y_cur, x_skip, y_skip;
    logic       skip_en;

    int checks = 0;
    int errors = 0;

    int m_routed [VC];
    int m_port   [VC];
    int m_rr;

    rc_arb_unit_if #(.VC_NUM(VC), .X(4), .Y(4), .L(3)) rc ();

    rc_arb_unit #(
        .DEST_ADDR_SIZE_X(4),
        .DEST_ADDR_SIZE_Y(4),
        .DEST_ADDR_SIZE_L(3),
        .VC_NUM(VC),
        .NUM_LOCAL(NL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .x_current(x_cur),
        .y_current(y_cur),
        .enable_skip(skip_en),
        .x_skip_dest(x_skip),
        .y_skip_dest(y_skip),
        .rc(rc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_route(input int xc, input int yc,
                                     input int xd, input int yd,
                                     input int ld, input int sk,
                                     input int xs, input int ys);
        if (xd == xc && yd == yc) begin
            if (ld < NL) return int'(DLA0) + ld;
            return sk ? int'(DLA0) + NL - 1 : int'(SKIP);
        end
        if (sk != 0 && xd == xs && yd == ys) return int'(SKIP);
        if (xd < xc) return int'(WEST);
        if (xd > xc) return int'(EAST);
        if (yd < yc) return int'(NORTH);
        return int'(SOUTH);
    endfunction

    // one clock: comb check, edge, model update, registered check
    task automatic cycle();
        int g;
        int np;
        int v;
        g  = -1;
        np = 0;
        #1;
        for (int i = 0; i < VC; i++) begin
            v = (m_rr + i) % VC;
            if (g < 0 && m_routed[v] == 0 && rc.req_valid[v]) g = v;
        end
        for (int i = 0; i < VC; i++)
            chk($sformatf("ready%0d", i), int'(rc.req_ready[i]),
                (rst_n && g == i) ? 1 : 0);
        if (g >= 0)
            np = ref_route(x_cur, y_cur, rc.x_dest[g], rc.y_dest[g],
                           rc.l_dest[g], skip_en, x_skip, y_skip);
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < VC; i++) begin
                m_routed[i] = 0;
                m_port[i]   = int'(DLA0);
            end
            m_rr = 0;
        end else begin
            for (int i = 0; i < VC; i++)
                if (m_routed[i] != 0 && rc.tail[i]) m_routed[i] = 0;
            if (g >= 0) begin
                m_routed[g] = 1;
                m_port[g]   = np;
                m_rr        = (g + 1) % VC;
            end
        end
        #1;
        for (int i = 0; i < VC; i++) begin
            chk($sformatf("rv%0d", i), int'(rc.route_valid[i]), m_routed[i]);
            chk($sformatf("port%0d", i), int'(rc.out_port[i]), m_port[i]);
        end
        @(negedge clk);
    endtask

    task automatic set_dest(input int v, input int x, input int y, input int l);
        rc.x_dest[v] = 4'(x);
        rc.y_dest[v] = 4'(y);
        rc.l_dest[v] = 3'(l);
    endtask

    task automatic route_one(input string tag, input int v, input int x,
                             input int y, input int l, input port_t exp);
        set_dest(v, x, y, l);
        rc.req_valid[v] = 1'b1;
        cycle();
        rc.req_valid[v] = 1'b0;
        chk(tag, int'(rc.out_port[v]), int'(exp));
        rc.tail[v] = 1'b1;
        cycle();
        rc.tail[v] = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        x_cur        = '0;
        y_cur        = '0;
        skip_en      = 1'b0;
        x_skip       = '0;
        y_skip       = '0;
        rc.req_valid = '1;
        rc.tail      = '0;
        rc.x_dest    = '0;
        rc.y_dest    = '0;
        rc.l_dest    = '0;
        m_rr         = 0;
        for (int i = 0; i < VC; i++) begin
            m_routed[i] = 0;
            m_port[i]   = int'(DLA0);
        end
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_port", int'(rc.out_port[0]), int'(DLA0));

        rst_n        = 1'b1;
        rc.req_valid = '0;
        x_cur = 4'd2; y_cur = 4'd2;
        route_one("east",  0, 5, 1, 0, EAST);
        route_one("north", 0, 2, 0, 0, NORTH);
        route_one("dla1",  0, 2, 2, 1, DLA1);
        x_cur = 4'd0; y_cur = 4'd0;
        route_one("nowrap_e", 0, 15, 0, 0, EAST);
        x_cur = 4'd15; y_cur = 4'd3;
        route_one("nowrap_w", 0, 0, 3, 0, WEST);
        x_cur = 4'd2; y_cur = 4'd2;
        skip_en = 1'b1; x_skip = 4'd7; y_skip = 4'd3;
        route_one("skip", 0, 7, 3, 0, SKIP);
        skip_en = 1'b0;
        route_one("l5_skip", 0, 2, 2, 5, SKIP);
        skip_en = 1'b1;
        route_one("l5_dla3", 0, 2, 2, 5, DLA3);
        skip_en = 1'b0;

        // VC1 grant wraps the pointer back to VC0
        route_one("vc1_east", 1, 4, 2, 0, EAST);
        set_dest(0, 1, 2, 0);
        set_dest(1, 2, 3, 0);
        rc.req_valid = 2'b11;
        cycle();
        chk("rr_vc0_rv", int'(rc.route_valid[0]), 1);
        chk("rr_vc1_wait", int'(rc.route_valid[1]), 0);
        rc.req_valid = 2'b10;
        cycle();
        chk("rr_vc1_rv", int'(rc.route_valid[1]), 1);
        rc.req_valid = 2'b01;
        rc.tail      = 2'b01;
        cycle();
        chk("tail_wins", int'(rc.route_valid[0]), 0);
        rc.tail = 2'b00;
        cycle();
        chk("reaccept", int'(rc.route_valid[0]), 1);
        rc.req_valid = 2'b00;
        rc.tail      = 2'b11;
        cycle();
        rc.tail = 2'b00;

        for (int n = 0; n < 400; n++) begin
            if (n % 40 == 0) begin
                x_cur   = 4'($urandom_range(0, 15));
                y_cur   = 4'($urandom_range(0, 15));
                skip_en = 1'($urandom_range(0, 1));
                x_skip  = 4'($urandom_range(0, 15));
                y_skip  = 4'($urandom_range(0, 15));
            end
            rst_n = (n >= 200 && n < 202) ? 1'b0 : 1'b1;
            for (int v = 0; v < VC; v++) begin
                set_dest(v,
                    ($urandom_range(0, 2) == 0) ? int'(x_cur) : $urandom_range(0, 15),
                    ($urandom_range(0, 2) == 0) ? int'(y_cur) : $urandom_range(0, 15),
                    $urandom_range(0, 7));
                if ($urandom_range(0, 5) == 0) begin
                    rc.x_dest[v] = x_skip;
                    rc.y_dest[v] = y_skip;
                end
            end
            rc.req_valid = 2'($urandom_range(0, 3));
            rc.tail      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
